// File: rtl/fft_stage_sequencer_pkg.sv
// Shared constants for the FFT stage sequencer: FSM state encodings and
// default pipeline latencies.
package fft_seq_pkg;
  localparam int BF_LAT_DEF = 4;
  localparam int RD_LAT_DEF = 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;
endpackage

// File: rtl/fft_stage_sequencer_if.sv
// Control/memory bus of the FFT stage sequencer. The master side is the FFT
// top level (en/start); the slave side is the sequencer itself.
// Optional macro FFT_SEQ_CYCLE_CNT_EN adds the 16-bit cycle_cnt signal.
interface fft_stage_sequencer_if #(
  parameter int LOG2N = 3
);
  localparam int SW = $clog2(LOG2N);

  logic             en;
  logic             start;
  logic             busy;
  logic             done;
  logic [SW-1:0]    stage;
  logic             rd_en;
  logic [LOG2N-1:0] rd_addr0;
  logic [LOG2N-1:0] rd_addr1;
  logic [LOG2N-2:0] tw_idx;
  logic             wr_en;
  logic [LOG2N-1:0] wr_addr0;
  logic [LOG2N-1:0] wr_addr1;
`ifdef FFT_SEQ_CYCLE_CNT_EN
  logic [15:0]      cycle_cnt;
`endif

  modport master (
`ifdef FFT_SEQ_CYCLE_CNT_EN
    input  cycle_cnt,
`endif
    output en, start,
    input  busy, done, stage, rd_en, rd_addr0, rd_addr1, tw_idx,
    input  wr_en, wr_addr0, wr_addr1
  );

  modport slave (
`ifdef FFT_SEQ_CYCLE_CNT_EN
    output cycle_cnt,
`endif
    input  en, start,
    output busy, done, stage, rd_en, rd_addr0, rd_addr1, tw_idx,
    output wr_en, wr_addr0, wr_addr1
  );
endinterface

// File: rtl/fft_stage_sequencer_addr_gen.sv
// Radix-2 DIT butterfly address generator: maps (stage, butterfly index)
// to the upper/lower leg addresses and the twiddle ROM index.
module fft_addr_gen #(
  parameter int LOG2N = 3,
  parameter int SW    = $clog2(LOG2N)
) (
  input  logic [SW-1:0]    stage_i,
  input  logic [LOG2N-2:0] b_i,
  output logic [LOG2N-1:0] addr0_o,
  output logic [LOG2N-1:0] addr1_o,
  output logic [LOG2N-2:0] tw_idx_o
);
  localparam int SHW = SW + 1;
  localparam int BW  = LOG2N - 1;

  logic [LOG2N-1:0] bx, half, pos, grp, a0;
  logic [SHW-1:0]   sh;

  // Split b into group/position within the current butterfly span; the lower
  // leg differs from the upper only in bit 'stage', so OR suffices.
  always_comb begin
    bx       = {1'b0, b_i};
    half     = LOG2N'(1) << stage_i;
    pos      = bx & (half - LOG2N'(1));
    grp      = bx >> stage_i;
    a0       = ((grp << stage_i) << 1) | pos;
    sh       = SHW'(LOG2N - 1) - {1'b0, stage_i};
    addr0_o  = a0;
    addr1_o  = a0 | half;
    tw_idx_o = BW'(pos << sh);
  end
endmodule

// File: rtl/fft_stage_sequencer.sv
// In-place radix-2 DIT FFT stage sequencer. Issues one butterfly read per
// enabled cycle, delays {addr pair, valid} by RD_LAT+BF_LAT to form the
// write-back, and drains that delay line before starting the next stage.
// Optional macro FFT_SEQ_CYCLE_CNT_EN adds a saturating 16-bit busy-cycle
// counter on bus.cycle_cnt.
module fft_stage_sequencer
  import fft_seq_pkg::*;
#(
  parameter int LOG2N  = 3,
  parameter int RD_LAT = RD_LAT_DEF,
  parameter int BF_LAT = BF_LAT_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  fft_stage_sequencer_if.slave  bus
);
  localparam int N        = 1 << LOG2N;
  localparam int HALF_N   = N / 2;
  localparam int PIPE_LAT = RD_LAT + BF_LAT;
  localparam int SW       = $clog2(LOG2N);
  localparam int BW       = LOG2N - 1;

  logic [1:0]    state_q, state_d;
  logic [SW-1:0] stage_q, stage_d;
  logic [BW-1:0] b_q, b_d;

  logic [PIPE_LAT-1:0]            vld_pipe_q;
  logic [PIPE_LAT-1:0][LOG2N-1:0] a0_pipe_q, a1_pipe_q;

  logic             issue;
  logic [LOG2N-1:0] ag_a0, ag_a1;
  logic [LOG2N-2:0] ag_tw;

  fft_addr_gen #(.LOG2N(LOG2N), .SW(SW)) u_addr_gen (
    .stage_i  (stage_q),
    .b_i      (b_q),
    .addr0_o  (ag_a0),
    .addr1_o  (ag_a1),
    .tw_idx_o (ag_tw)
  );

  // Next-state: issue HALF_N butterflies, then wait for the delay line to
  // empty so the next stage never reads a location still being written.
  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    b_d     = b_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_ISSUE;
          stage_d = '0;
          b_d     = '0;
        end
      end
      S_ISSUE: begin
        b_d = b_q + BW'(1);
        if (b_q == BW'(HALF_N - 1)) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (vld_pipe_q == '0) begin
          if (stage_q == SW'(LOG2N - 1)) begin
            state_d = S_DONE;
          end else begin
            stage_d = stage_q + SW'(1);
            state_d = S_ISSUE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM registers; en=0 freezes everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      stage_q <= '0;
      b_q     <= '0;
    end else if (bus.en) begin
      state_q <= state_d;
      stage_q <= stage_d;
      b_q     <= b_d;
    end
  end

  assign issue = (state_q == S_ISSUE);

  // Read-side outputs are zero outside ISSUE so idle/reset shows clean zeros.
  assign bus.rd_en    = issue;
  assign bus.rd_addr0 = issue ? ag_a0 : '0;
  assign bus.rd_addr1 = issue ? ag_a1 : '0;
  assign bus.tw_idx   = issue ? ag_tw : '0;

  // Write-back delay line: read pair and strobe shifted PIPE_LAT enabled cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe_q <= '0;
      a0_pipe_q  <= '0;
      a1_pipe_q  <= '0;
    end else if (bus.en) begin
      vld_pipe_q <= {vld_pipe_q[PIPE_LAT-2:0], bus.rd_en};
      a0_pipe_q  <= {a0_pipe_q[PIPE_LAT-2:0], bus.rd_addr0};
      a1_pipe_q  <= {a1_pipe_q[PIPE_LAT-2:0], bus.rd_addr1};
    end
  end

  assign bus.wr_en    = vld_pipe_q[PIPE_LAT-1];
  assign bus.wr_addr0 = a0_pipe_q[PIPE_LAT-1];
  assign bus.wr_addr1 = a1_pipe_q[PIPE_LAT-1];

  assign bus.busy  = (state_q != S_IDLE);
  assign bus.done  = (state_q == S_DONE);
  assign bus.stage = stage_q;

`ifdef FFT_SEQ_CYCLE_CNT_EN
  logic [15:0] cnt_q;

  // Busy-cycle counter: cleared by an accepted start, saturating, held when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (bus.en) begin
      if (state_q == S_IDLE && bus.start)
        cnt_q <= '0;
      else if (state_q != S_IDLE && cnt_q != 16'hFFFF)
        cnt_q <= cnt_q + 16'd1;
    end
  end

  assign bus.cycle_cnt = cnt_q;
`endif
endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Directed bench for fft_stage_sequencer: default N=8 instance plus an N=16,
// BF_LAT=2 instance, checked against hand-computed address/timing tables.
module tb_fft_stage_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fft_stage_sequencer_if #(.LOG2N(3)) bus ();
  fft_stage_sequencer_if #(.LOG2N(4)) bus4 ();

  fft_stage_sequencer #(.LOG2N(3), .RD_LAT(1), .BF_LAT(4)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  fft_stage_sequencer #(.LOG2N(4), .RD_LAT(1), .BF_LAT(2)) dut4 (
    .clk(clk), .rst_n(rst_n), .bus(bus4)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Hand-derived butterfly order for N=8: stage0, stage1, stage2.
  int exp_a0[12] = '{0, 2, 4, 6,  0, 1, 4, 5,  0, 1, 2, 3};
  int exp_a1[12] = '{1, 3, 5, 7,  2, 3, 6, 7,  4, 5, 6, 7};
  int exp_tw[12] = '{0, 0, 0, 0,  0, 2, 0, 2,  0, 1, 2, 3};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int rd4, done4_c, done4_n, done_c, done_n, wr_n, rd_n;
    int tw4[$];
    int wq0[$];
    int wq1[$];

    bus.en = 1'b1;  bus.start = 1'b0;
    bus4.en = 1'b1; bus4.start = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy",  bus.busy, 0);
    chk("rst_done",  bus.done, 0);
    chk("rst_rd_en", bus.rd_en, 0);
    chk("rst_wr_en", bus.wr_en, 0);
    chk("rst_stage", bus.stage, 0);
    chk("rst_ra0",   bus.rd_addr0, 0);
    chk("rst_ra1",   bus.rd_addr1, 0);
    chk("rst_tw",    bus.tw_idx, 0);
    chk("rst_wa0",   bus.wr_addr0, 0);
    chk("rst_wa1",   bus.wr_addr1, 0);
    rst_n = 1'b1;
    step();

    // Full transform on both instances; start sampled at edge 0.
    bus.start = 1'b1; bus4.start = 1'b1;
    step();
    bus.start = 1'b0; bus4.start = 1'b0;
    rd4 = 0; done4_c = 0; done4_n = 0;
    for (int c = 1; c <= 50; c++) begin
      if (c <= 32) begin
        int s, k;
        bit erd, ewr;
        s = (c - 1) / 10;
        k = (c - 1) % 10;
        erd = (c <= 30) && (k < 4);
        ewr = (c <= 30) && (k >= 5) && (k <= 8);
        chk($sformatf("t1_rd_en_c%0d", c), bus.rd_en, erd);
        chk($sformatf("t1_wr_en_c%0d", c), bus.wr_en, ewr);
        chk($sformatf("t1_done_c%0d", c), bus.done, c == 31);
        chk($sformatf("t1_busy_c%0d", c), bus.busy, c <= 31);
        if (c <= 31) chk($sformatf("t1_stage_c%0d", c), bus.stage, (c == 31) ? 2 : s);
        if (erd) begin
          chk($sformatf("t1_ra0_c%0d", c), bus.rd_addr0, exp_a0[s*4+k]);
          chk($sformatf("t1_ra1_c%0d", c), bus.rd_addr1, exp_a1[s*4+k]);
          chk($sformatf("t1_tw_c%0d", c),  bus.tw_idx,   exp_tw[s*4+k]);
        end
        if (ewr) begin
          chk($sformatf("t1_wa0_c%0d", c), bus.wr_addr0, exp_a0[s*4+k-5]);
          chk($sformatf("t1_wa1_c%0d", c), bus.wr_addr1, exp_a1[s*4+k-5]);
        end
`ifdef FFT_SEQ_CYCLE_CNT_EN
        if (c == 32) chk("t1_cycle_cnt", bus.cycle_cnt, 31);
`endif
      end
      if (bus4.rd_en) begin
        rd4++;
        if (bus4.stage == 3) tw4.push_back(int'(bus4.tw_idx));
      end
      if (bus4.done) begin
        done4_n++;
        if (done4_c == 0) done4_c = c;
      end
      if (c == 50) chk("n16_busy_c50", bus4.busy, 0);
      step();
    end
    chk("n16_reads", rd4, 32);
    chk("n16_done_cycle", done4_c, 49);
    chk("n16_done_pulses", done4_n, 1);
    chk("n16_s3_tw_count", tw4.size(), 8);
    for (int i = 0; i < tw4.size() && i < 8; i++)
      chk($sformatf("n16_s3_tw%0d", i), tw4[i], i);

    // en low for three cycles during ISSUE of stage 0.
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    done_c = 0;
    for (int c = 1; c <= 40; c++) begin
      if (c >= 3 && c <= 5) begin
        chk($sformatf("t2_frz_rd_en_c%0d", c), bus.rd_en, 1);
        chk($sformatf("t2_frz_ra0_c%0d", c), bus.rd_addr0, 2);
        chk($sformatf("t2_frz_ra1_c%0d", c), bus.rd_addr1, 3);
        chk($sformatf("t2_frz_wr_en_c%0d", c), bus.wr_en, 0);
      end
      if (bus.wr_en) begin
        wq0.push_back(int'(bus.wr_addr0));
        wq1.push_back(int'(bus.wr_addr1));
      end
      if (bus.done && done_c == 0) done_c = c;
      if (c == 35) chk("t2_busy_c35", bus.busy, 0);
      if (c == 2) bus.en = 1'b0;
      if (c == 5) bus.en = 1'b1;
      step();
    end
    chk("t2_done_cycle", done_c, 34);
    chk("t2_wr_count", wq0.size(), 12);
    for (int i = 0; i < wq0.size() && i < 12; i++) begin
      chk($sformatf("t2_wa0_%0d", i), wq0[i], exp_a0[i]);
      chk($sformatf("t2_wa1_%0d", i), wq1[i], exp_a1[i]);
    end

    // start held high: re-accepted only after returning to IDLE.
    bus.start = 1'b1;
    step();
    done_c = 0; done_n = 0;
    for (int c = 1; c <= 34; c++) begin
      if (bus.done) begin
        done_n++;
        if (done_c == 0) done_c = c;
      end
      if (c == 20) chk("t3_stage_c20", bus.stage, 1);
      if (c == 32) chk("t3_busy_c32", bus.busy, 0);
      if (c == 33) begin
        chk("t3_restart_rd_en", bus.rd_en, 1);
        chk("t3_restart_stage", bus.stage, 0);
        chk("t3_restart_ra0", bus.rd_addr0, 0);
        chk("t3_restart_ra1", bus.rd_addr1, 1);
        chk("t3_restart_busy", bus.busy, 1);
      end
      step();
    end
    chk("t3_done_cycle", done_c, 31);
    chk("t3_done_pulses", done_n, 1);
    bus.start = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();

    // Reset asserted during stage 1 ISSUE.
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    repeat (12) step();
    chk("t4_pre_rd_en", bus.rd_en, 1);
    chk("t4_pre_stage", bus.stage, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t4_async_rd_en", bus.rd_en, 0);
    chk("t4_async_busy", bus.busy, 0);
    step();
    chk("t4_rd_en", bus.rd_en, 0);
    chk("t4_wr_en", bus.wr_en, 0);
    chk("t4_busy", bus.busy, 0);
    chk("t4_stage", bus.stage, 0);
    rst_n = 1'b1;
    wr_n = 0; rd_n = 0;
    for (int c = 0; c < 20; c++) begin
      if (bus.wr_en) wr_n++;
      if (bus.rd_en) rd_n++;
      step();
    end
    chk("t4_no_wr_after_rst", wr_n, 0);
    chk("t4_no_rd_after_rst", rd_n, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
